// File: rtl/clkdiv_prog_if.sv
// rtl/clkdiv_prog_if.sv - control and status bundle for the programmable clock divider
interface clkdiv_prog_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic [WIDTH-1:0] div;
   logic             load;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic [WIDTH-1:0] cur_div;

   modport master (
      output en, div, load,
      input  clk_out, tick, busy, cur_div
   );

   modport slave (
      input  en, div, load,
      output clk_out, tick, busy, cur_div
   );
endinterface

// File: rtl/clkdiv_prog.sv
// rtl/clkdiv_prog.sv - runtime-programmable glitch-free clock divider with tick strobe
module clkdiv_prog #(
   parameter int WIDTH     = 16,
   parameter int RESET_DIV = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   clkdiv_prog_if.slave bus
);
   localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] n, n_nx;
   logic [WIDTH-1:0] pending, pending_nx;
   logic [WIDTH-1:0] h_nx;
   logic             busy_q, busy_nx;
   logic             clk_q, clk_nx;
   logic             tick_q, tick_nx;
   logic             at_end;
   logic             wrap;

   always_comb begin
      cnt_nx     = cnt;
      n_nx       = n;
      pending_nx = pending;
      busy_nx    = busy_q;
      wrap       = 1'b0;
      at_end     = (cnt == n - ONE);

      // A period in progress always completes; en is only consulted at its end.
      if (!at_end) begin
         cnt_nx = cnt + ONE;
      end else if (bus.en) begin
         wrap   = 1'b1;
         cnt_nx = '0;
         if (busy_q) begin
            n_nx    = pending;
            busy_nx = 1'b0;
         end
      end else if (busy_q) begin
         // Halted: swap ratio in place and park at the new end-of-period.
         n_nx    = pending;
         cnt_nx  = pending - ONE;
         busy_nx = 1'b0;
      end

      // A load on the same edge supersedes the busy clear above.
      if (bus.load) begin
         pending_nx = (bus.div < MIN_DIV) ? MIN_DIV : bus.div;
         busy_nx    = 1'b1;
      end

      h_nx    = n_nx >> 1;
      clk_nx  = (cnt_nx < h_nx);
      tick_nx = wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= RST_DIV - ONE;
         n       <= RST_DIV;
         pending <= '0;
         busy_q  <= 1'b0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         cnt     <= cnt_nx;
         n       <= n_nx;
         pending <= pending_nx;
         busy_q  <= busy_nx;
         clk_q   <= clk_nx;
         tick_q  <= tick_nx;
      end
   end

   assign bus.clk_out = clk_q;
   assign bus.tick    = tick_q;
   assign bus.busy    = busy_q;
   assign bus.cur_div = n;
endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
Runtime-programmable clock divider and enable generator. It is the parametrised successor of the fixed-ratio divider. It produces a registered, glitch-free divided clock plus a one-cycle tick strobe from a single input clock. The divide ratio can be changed while running without runt pulses, and the output can be started and stopped cleanly. It feeds slow peripherals and debug single-step logic in the CPU top level.

Parameters:
WIDTH, 16, width of divide-ratio field and internal counter
RESET_DIV, 2, active divide ratio N after reset (must be >= 2 and < 2^WIDTH)

Ports:
clk  input  1  input clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  run request; level-sensitive
div  input  WIDTH  requested divide ratio N (output period = N clk cycles)
load  input  1  single-cycle pulse: capture div as pending ratio
clk_out  output  1  divided clock, driven directly from a flop
tick  output  1  one-clk pulse in the cycle clk_out rises
busy  output  1  pending ratio captured, not yet applied
cur_div  output  WIDTH  active ratio N

Behaviour:
- Reset (rst_n low, async): N=RESET_DIV, cnt=N-1, clk_out=0, tick=0, busy=0, pending cleared, cur_div=RESET_DIV.
- Internal counter cnt runs 0..N-1. H = N>>1 (floor). High phase = H cycles, low phase = N-H cycles; odd N gives the longer low phase.
- Outputs are registered from next-state values:
  - clk_out <= (cnt_next < H_next).
  - tick <= (cnt_next == 0) && wrap occurred.
  - No combinational path from any input to any output.
- Each rising edge:
  - cnt != N-1: cnt <= cnt+1, regardless of en. The current period always completes.
  - cnt == N-1 and en=1: wrap. cnt <= 0; if busy, N <= pending and busy <= 0 (same edge); clk_out rises, tick=1.
  - cnt == N-1 and en=0: halt. cnt holds, clk_out=0, tick=0. If busy, N <= pending, cnt <= pending-1, busy <= 0.
- Start latency: with the block halted, en rises before edge k → clk_out=1 and tick=1 after edge k. There is no extra cycle of latency.
- Stop: en falling mid-period finishes the period, then holds low. No truncated high or low phase ever occurs.
- Load handling:
  - load=1 captures clamp(div) into pending; busy=1 from the next cycle.
  - clamp: div<2 → 2.
  - load while busy overwrites pending (last wins).
  - load on the same edge as a wrap: the wrap applies the old pending, if any; the new value becomes pending and busy=1.
- cur_div updates on the same edge the new N takes effect.
- Reset mid-operation forces reset values immediately (async), regardless of clk. The first wrap after release requires en=1.

Test Plan:
- Reset: hold rst_n=0 with clk toggling → clk_out=0, tick=0, busy=0, cur_div=2. Release with en=1 → edges 1,3,5… clk_out=1 (period 2), tick on the same edges.
- N=4, en=1 continuous → clk_out pattern 1100 repeating, tick on every 4th edge, first at edge 1 after en.
- N=5 → clk_out pattern 11000 repeating, period 5, tick once per period.
- Running N=4, load div=6 at cnt=1 → busy=1 for the rest of the period, then pattern 111000 starts at the wrap; cur_div 4→6 and busy→0 at that edge.
- en dropped at cnt=0 with N=8 → clk_out stays high 4 cycles, low 4 cycles, then held 0, tick=0. en reasserted → clk_out=1 and tick=1 on the next edge.
- load div=0 → cur_div becomes 2 at the next wrap. A second load div=3 while busy → 3 is applied, not 2.
- rst_n pulsed low mid-high-phase (N=6) → clk_out=0 and cur_div=RESET_DIV asynchronously, with no clk edge needed.
